// File: rtl/ifu_prefetch.sv
// Decoupled instruction prefetcher: PC generator, credit-limited imem request port
// and a FIFO_DEPTH-entry instruction/PC buffer feeding decode over valid/ready.
module ifu_prefetch #(
    parameter int unsigned     PC_W        = 32,
    parameter int unsigned     INSTR_W     = 32,
    parameter int unsigned     FIFO_DEPTH  = 4,
    parameter logic [PC_W-1:0] PC_RST_ADDR = '0,
    parameter logic [PC_W-1:0] PC_INC      = 4
) (
    input  logic               clk_sys,
    input  logic               rst_sys_n,
    output logic               o_instr_req,
    input  logic               i_instr_gnt,
    output logic [PC_W-1:0]    o_instr_raddr,
    input  logic               i_instr_rvalid,
    input  logic [INSTR_W-1:0] i_instr_rdata,
    input  logic               i_jump_en,
    input  logic [PC_W-1:0]    i_jump_addr,
    output logic               o_instr_valid,
    input  logic               i_instr_ready,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [PC_W-1:0]    fpc_q, fpc_d, rpc_q, rpc_d;
    logic [CW-1:0]      outst_q, outst_d, discard_q, discard_d, count_q, count_d;
    logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [INSTR_W-1:0] instr_mem_q [FIFO_DEPTH];
    logic [PC_W-1:0]    pc_mem_q [FIFO_DEPTH];
    logic               rsp, gnt, push, pop;
    logic [CW:0]        credit;

    always_comb begin
        credit      = {1'b0, outst_q} + {1'b0, count_q};
        o_instr_req = !i_jump_en && (credit < DEPTH_C);
        gnt         = o_instr_req && i_instr_gnt;
        // rvalid with nothing outstanding is a protocol error and is ignored
        rsp         = i_instr_rvalid && (outst_q != '0);
        pop         = (count_q != '0) && i_instr_ready && !i_jump_en;
        push        = rsp && (discard_q == '0) && !i_jump_en;

        fpc_d     = fpc_q;
        rpc_d     = rpc_q;
        outst_d   = outst_q;
        discard_d = discard_q;
        count_d   = count_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;

        if (i_jump_en) begin
            // responses still in flight after this cycle belong to the old stream
            fpc_d     = i_jump_addr;
            rpc_d     = i_jump_addr;
            outst_d   = outst_q - CW'(rsp);
            discard_d = outst_q - CW'(rsp);
            count_d   = '0;
            wptr_d    = '0;
            rptr_d    = '0;
        end else begin
            outst_d = outst_q + CW'(gnt) - CW'(rsp);
            if (rsp && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                wptr_d = wptr_q + AW'(1);
                rpc_d  = rpc_q + PC_INC;
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (gnt) begin
                fpc_d = fpc_q + PC_INC;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            fpc_q     <= PC_RST_ADDR;
            rpc_q     <= PC_RST_ADDR;
            outst_q   <= '0;
            discard_q <= '0;
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            fpc_q     <= fpc_d;
            rpc_q     <= rpc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            if (push) begin
                instr_mem_q[wptr_q] <= i_instr_rdata;
                pc_mem_q[wptr_q]    <= rpc_q;
            end
        end
    end

    always_comb begin
        o_instr_raddr = fpc_q;
        o_instr_valid = (count_q != '0);
        o_instr       = o_instr_valid ? instr_mem_q[rptr_q] : '0;
        o_pc          = o_instr_valid ? pc_mem_q[rptr_q] : '0;
    end

    a_no_overflow: assert property (@(posedge clk_sys) disable iff (!rst_sys_n)
        push |-> (({1'b0, count_q} < DEPTH_C) || pop));
    a_rvalid_proto: assert property (@(posedge clk_sys) disable iff (!rst_sys_n)
        i_instr_rvalid |-> (outst_q != '0));
    a_discard_bound: assert property (@(posedge clk_sys) disable iff (!rst_sys_n)
        discard_q <= outst_q);

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized bench for ifu_prefetch: an in-order imem responder plus a queue-based
// reference model of fetch addresses, in-flight responses and the decode buffer.
module tb_ifu_prefetch;
    localparam int unsigned    DEPTH = 4;
    localparam logic [31:0]    RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0]    INC = 32'd4;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n = 1'b0;
    logic        o_instr_req;
    logic        i_instr_gnt = 1'b0;
    logic [31:0] o_instr_raddr;
    logic        i_instr_rvalid = 1'b0;
    logic [31:0] i_instr_rdata = '0;
    logic        i_jump_en = 1'b0;
    logic [31:0] i_jump_addr = '0;
    logic        o_instr_valid;
    logic        i_instr_ready = 1'b0;
    logic [31:0] o_instr;
    logic [31:0] o_pc;

    ifu_prefetch #(
        .PC_W        (32),
        .INSTR_W     (32),
        .FIFO_DEPTH  (DEPTH),
        .PC_RST_ADDR (RST_PC),
        .PC_INC      (INC)
    ) dut (
        .clk_sys        (clk_sys),
        .rst_sys_n      (rst_sys_n),
        .o_instr_req    (o_instr_req),
        .i_instr_gnt    (i_instr_gnt),
        .o_instr_raddr  (o_instr_raddr),
        .i_instr_rvalid (i_instr_rvalid),
        .i_instr_rdata  (i_instr_rdata),
        .i_jump_en      (i_jump_en),
        .i_jump_addr    (i_jump_addr),
        .o_instr_valid  (o_instr_valid),
        .i_instr_ready  (i_instr_ready),
        .o_instr        (o_instr),
        .o_pc           (o_pc)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct { logic [31:0] data; int due; } rsp_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    rsp_t        memq[$];
    ent_t        mq[$];
    logic [31:0] m_fpc, m_rpc;
    int          m_out, m_disc, cyc;
    int          n_chk = 0, n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        memq.delete();
        mq.delete();
        m_fpc  = RST_PC;
        m_rpc  = RST_PC;
        m_out  = 0;
        m_disc = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(o_instr_valid), 32'd0);
        check_eq({tag, "_instr"}, o_instr, 32'd0);
        check_eq({tag, "_pc"}, o_pc, 32'd0);
        check_eq({tag, "_raddr"}, o_instr_raddr, RST_PC);
        check_eq({tag, "_req"}, 32'(o_instr_req), 32'd1);
    endtask

    task automatic run_cycles(input int n, input int jp, input int rp, input int gp, input int dmax);
        logic e_req, e_valid;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_sys);
            i_jump_en   = ($urandom_range(99) < jp);
            i_jump_addr = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + (32'($urandom_range(7)) << 2))
                                                   : ($urandom & 32'hFFFF_FFFC);
            i_instr_ready = ($urandom_range(99) < rp);
            i_instr_gnt   = ($urandom_range(99) < gp);
            i_instr_rvalid = (memq.size() > 0) && (memq[0].due <= cyc);
            i_instr_rdata  = i_instr_rvalid ? memq[0].data : $urandom;
            if (i_instr_rvalid) void'(memq.pop_front());
            #1;
            e_req   = !i_jump_en && (m_out + mq.size() < DEPTH);
            e_valid = (mq.size() != 0);
            check_eq("req", 32'(o_instr_req), 32'(e_req));
            check_eq("raddr", o_instr_raddr, m_fpc);
            check_eq("valid", 32'(o_instr_valid), 32'(e_valid));
            check_eq("instr", o_instr, e_valid ? mq[0].instr : 32'd0);
            check_eq("pc", o_pc, e_valid ? mq[0].pc : 32'd0);

            if (i_jump_en) begin
                if (i_instr_rvalid) m_out--;
                m_disc = m_out;
                mq.delete();
                m_fpc = i_jump_addr;
                m_rpc = i_jump_addr;
            end else begin
                if (e_valid && i_instr_ready) void'(mq.pop_front());
                if (i_instr_rvalid) begin
                    m_out--;
                    if (m_disc > 0) m_disc--;
                    else begin
                        mq.push_back('{instr: i_instr_rdata, pc: m_rpc});
                        m_rpc = m_rpc + INC;
                    end
                end
                if (e_req && i_instr_gnt) begin
                    memq.push_back('{data: $urandom, due: cyc + $urandom_range(dmax, 1)});
                    m_fpc = m_fpc + INC;
                    m_out++;
                end
            end
            cyc++;
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        repeat (3) @(negedge clk_sys);
        check_reset_outputs("rst");
        rst_sys_n = 1'b1;

        // streaming, fill with decode stalled, drain, then random mixes incl. jumps
        run_cycles(30, 0, 100, 100, 1);
        run_cycles(12, 0, 0, 100, 1);
        run_cycles(12, 0, 100, 100, 1);
        run_cycles(400, 5, 70, 70, 3);
        run_cycles(400, 25, 60, 80, 3);

        // asynchronous reset pulse between clock edges, with a stray response during reset
        @(negedge clk_sys);
        i_jump_en = 1'b0;
        i_instr_gnt = 1'b0;
        i_instr_rvalid = 1'b0;
        i_instr_ready = 1'b0;
        #2 rst_sys_n = 1'b0;
        #1 check_reset_outputs("arst");
        @(negedge clk_sys);
        i_instr_rvalid = 1'b1;
        i_instr_rdata  = 32'hDEAD_BEEF;
        @(negedge clk_sys);
        i_instr_rvalid = 1'b0;
        check_reset_outputs("arst_hold");
        model_reset();
        rst_sys_n = 1'b1;

        run_cycles(20, 0, 100, 100, 1);
        run_cycles(300, 10, 70, 70, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised successor fetch unit: decoupled instruction prefetcher with a PC generator, a credit-limited request/grant/rvalid imem interface and a FIFO_DEPTH-entry instruction/PC buffer.
- Decode consumes entries over a valid/ready handshake.
- A jump from execute redirects fetch, clears the buffer and drops in-flight responses.
- Sits between imem and the decode stage.

Parameters:
- PC_W, 32, PC / address width
- INSTR_W, 32, instruction width
- FIFO_DEPTH, 4, buffer entries and max in-flight requests; power of two, >=2
- PC_RST_ADDR, 0, PC value after reset
- PC_INC, 4, PC increment per fetch

Ports:
- clk_sys  in  1  system clock
- rst_sys_n  in  1  async active-low reset
- o_instr_req  out  1  fetch request
- i_instr_gnt  in  1  imem accepts request this cycle
- o_instr_raddr  out  PC_W  fetch address
- i_instr_rvalid  in  1  response valid (in order, >=1 cycle after grant)
- i_instr_rdata  in  INSTR_W  response data
- i_jump_en  in  1  redirect request
- i_jump_addr  in  PC_W  redirect target
- o_instr_valid  out  1  buffer head valid
- i_instr_ready  in  1  decode accepts head (low = decode stall)
- o_instr  out  INSTR_W  head instruction
- o_pc  out  PC_W  head PC

Behaviour:
- Reset (async assert, sync use after deassert):
  - fpc = rpc = PC_RST_ADDR
  - outstanding = discard = count = 0
  - o_instr_valid = 0
  - o_instr and o_pc = 0 while empty (head entries reset to 0)
  - o_instr_req = 1 in the first cycle after deassertion
- State:
  - fpc: next fetch address
  - rpc: PC of the next kept response
  - outstanding: granted but not yet responded, 0..FIFO_DEPTH
  - discard: responses to drop, <= outstanding
  - count: FIFO occupancy
- Request:
  - o_instr_req = ~i_jump_en && (outstanding + count < FIFO_DEPTH)
  - o_instr_raddr = fpc
  - req && gnt -> fpc += PC_INC, outstanding += 1
  - Address is held while req is high without gnt.
- Response: i_instr_rvalid -> outstanding -= 1, then:
  - discard != 0: data dropped, discard -= 1
  - else: push {rdata, rpc}, rpc += PC_INC
- Grant and response in the same cycle: outstanding unchanged.
- Output:
  - o_instr_valid = (count != 0); o_instr / o_pc from head.
  - valid && ready -> pop.
  - Push and pop in the same cycle: count unchanged.
  - Latency: response in cycle t -> visible at head in t+1 if the FIFO was empty.
- Credit rule guarantees count <= FIFO_DEPTH - outstanding, so a push never meets a full FIFO. No overflow logic; an assertion checks it.
- Jump (i_jump_en = 1), overriding all else:
  - FIFO cleared (count = 0); any pop that cycle is void.
  - fpc = rpc = i_jump_addr.
  - No request issued that cycle.
  - discard = outstanding - (i_instr_rvalid ? 1 : 0); a response arriving in the jump cycle is dropped.
  - outstanding keeps counting the dropped responses.
  - First fetch of i_jump_addr issues in the next cycle.
- Back-to-back jumps: the last one wins; discard is recomputed each time.
- PC arithmetic is modulo 2^PC_W (wraps silently).
- i_instr_rvalid with outstanding == 0 is a protocol error: ignored, counters unchanged, assertion fires.
- Reset mid-operation clears everything immediately. Responses arriving after reset are ignored under the rule above.
- Throughput: with gnt = 1, single-cycle rvalid and ready = 1, one instruction per cycle sustained.

Test Plan:
1. Reset release, gnt = 1, rvalid 1 cycle after grant, ready = 1 -> raddr 0, 4, 8, … one per cycle; o_instr_valid rises 2 cycles after the first req; o_pc = 0, 4, 8 consecutive with matching data.
2. FIFO_DEPTH = 4, ready = 0 -> exactly 4 grants (0x0–0xC), then req = 0 and count = 4. Ready = 1 -> pops 0x0…0xC one per cycle; req reasserts the cycle after the first pop with raddr 0x10.
3. Two requests outstanding (0x8, 0xC, rvalid delayed 3 cycles), jump to 0x100 -> both responses dropped; FIFO empty. Next req raddr 0x100 the cycle after the jump; first output o_pc = 0x100.
4. Jump coincident with rvalid and a pop (count = 2) -> that response dropped, o_instr_valid = 0 next cycle, discard = outstanding - 1.
5. PC_RST_ADDR = 0xFFFFFFF8 -> fetched PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
6. rst_sys_n pulsed low mid-stream between clock edges -> all outputs cleared asynchronously; after release, fetch restarts at PC_RST_ADDR; stray rvalid ignored.
